// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: reusable valid/ready pipeline stage with optional skid entry, freeze, flush and saturating counters.
module pipe_stage_reg #(
    parameter int                 DATA_W  = 32,
    parameter logic [DATA_W-1:0]  NOP_VAL = '0,
    parameter bit                 SKID    = 1'b1,
    parameter int                 CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              freeze,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  freeze_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);
    logic              main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [CNT_W-1:0]  freeze_cnt_q, freeze_cnt_d, flush_cnt_q, flush_cnt_d, drop_cnt_q, drop_cnt_d;
    logic              t_in, t_out;
    logic [1:0]        n_drop;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] q, input logic [1:0] inc);
        logic [CNT_W:0] s;
        s = {1'b0, q} + (CNT_W+1)'(inc);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    assign out_valid  = main_valid_q & ~freeze;
    assign out_data   = main_data_q;
    assign in_ready   = (SKID ? ~skid_valid_q : (~main_valid_q | out_ready)) & ~freeze & ~flush & rst;
    assign t_out      = out_valid & out_ready;
    assign t_in       = in_valid & in_ready;
    assign freeze_cnt = freeze_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign drop_cnt   = drop_cnt_q;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        n_drop       = '0;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            main_data_d  = NOP_VAL;
            n_drop       = 2'(main_valid_q & ~t_out) + 2'(skid_valid_q);
        end else if (!freeze) begin
            if (skid_valid_q) begin
                if (t_out) begin
                    main_data_d  = skid_data_q;
                    skid_valid_d = 1'b0;
                end
            end else if (t_in && (!main_valid_q || t_out)) begin
                main_data_d  = in_data;
                main_valid_d = 1'b1;
            end else if (t_in) begin
                skid_data_d  = in_data;
                skid_valid_d = SKID;
            end else if (t_out) begin
                main_valid_d = 1'b0;
            end
        end
        freeze_cnt_d = cnt_clr ? '0 : sat_add(freeze_cnt_q, {1'b0, freeze});
        flush_cnt_d  = cnt_clr ? '0 : sat_add(flush_cnt_q, {1'b0, flush});
        drop_cnt_d   = cnt_clr ? '0 : sat_add(drop_cnt_q, n_drop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= NOP_VAL;
            skid_valid_q <= 1'b0;
            skid_data_q  <= NOP_VAL;
            freeze_cnt_q <= '0;
            flush_cnt_q  <= '0;
            drop_cnt_q   <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            freeze_cnt_q <= freeze_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed stimulus with a scoreboard queue checked by an independent output monitor.
module tb_pipe_stage_reg;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0, freeze = 1'b0, flush = 1'b0, cnt_clr = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready1, out_valid1, in_ready0, out_valid0, in_ready2, out_valid2;
    logic [31:0] out_data1, out_data0, out_data2;
    logic [15:0] frz1, fls1, drp1, frz0, fls0, drp0;
    logic [1:0]  frz2, fls2, drp2;
    logic [31:0] sb[$];
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .NOP_VAL(32'h0), .SKID(1'b1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
        .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready), .freeze(freeze),
        .flush(flush), .cnt_clr(cnt_clr), .freeze_cnt(frz1), .flush_cnt(fls1), .drop_cnt(drp1));

    pipe_stage_reg #(.DATA_W(32), .NOP_VAL(32'h0), .SKID(1'b0), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
        .out_valid(out_valid0), .out_data(out_data0), .out_ready(out_ready), .freeze(freeze),
        .flush(flush), .cnt_clr(cnt_clr), .freeze_cnt(frz0), .flush_cnt(fls0), .drop_cnt(drp0));

    pipe_stage_reg #(.DATA_W(32), .NOP_VAL(32'h0), .SKID(1'b1), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
        .out_valid(out_valid2), .out_data(out_data2), .out_ready(out_ready), .freeze(freeze),
        .flush(flush), .cnt_clr(cnt_clr), .freeze_cnt(frz2), .flush_cnt(fls2), .drop_cnt(drp2));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted output beat must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst && out_valid1 && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_out: got %h expected none", out_data1);
            end else begin
                chk("sb_out", out_data1, sb.pop_front());
            end
        end
    end

    initial begin
        #2;
        chk("rst_out_valid", {31'b0, out_valid1}, 32'd0);
        chk("rst_out_data", out_data1, 32'h0);
        chk("rst_in_ready", {31'b0, in_ready1}, 32'd0);
        chk("rst_cnts", {frz1, drp1}, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rel_in_ready", {31'b0, in_ready1}, 32'd1);

        // Streaming, 1-cycle latency, 1 per cycle
        in_valid = 1'b1; in_data = 32'h11; out_ready = 1'b1; sb.push_back(32'h11);
        #1 chk("pre_first_valid", {31'b0, out_valid1}, 32'd0);
        tick();
        in_data = 32'h22; sb.push_back(32'h22);
        #1 chk("s1_data", out_data1, 32'h11);
        chk("s1_valid", {31'b0, out_valid1}, 32'd1);
        tick();
        in_data = 32'h33; sb.push_back(32'h33);
        #1 chk("s2_data", out_data1, 32'h22);
        tick();
        in_valid = 1'b0;
        #1 chk("s3_data", out_data1, 32'h33);
        tick();
        #1 chk("s_empty", {31'b0, out_valid1}, 32'd0);

        // Skid entry absorbs one beat under backpressure
        in_valid = 1'b1; in_data = 32'hA; out_ready = 1'b0; sb.push_back(32'hA);
        tick();
        in_data = 32'hB; sb.push_back(32'hB);
        #1 chk("skid_in_ready", {31'b0, in_ready1}, 32'd1);
        chk("noskid_in_ready_bp", {31'b0, in_ready0}, 32'd0);
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        #1 chk("skid_full_ready", {31'b0, in_ready1}, 32'd0);
        chk("skid_head", out_data1, 32'hA);
        chk("noskid_in_ready_go", {31'b0, in_ready0}, 32'd1);
        tick();
        #1 chk("skid_drain_ready", {31'b0, in_ready1}, 32'd1);
        chk("skid_second", out_data1, 32'hB);
        tick();

        // Flush with both entries occupied
        in_valid = 1'b1; in_data = 32'hA; out_ready = 1'b0;
        tick();
        in_data = 32'hB;
        tick();
        in_data = 32'hEE; flush = 1'b1;
        #1 chk("flush_in_ready", {31'b0, in_ready1}, 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1 chk("flush_valid", {31'b0, out_valid1}, 32'd0);
        chk("flush_nop", out_data1, 32'h0);
        chk("flush_drop", {16'b0, drp1}, 32'd2);
        chk("flush_cnt", {16'b0, fls1}, 32'd1);
        out_ready = 1'b1;
        tick();
        #1 chk("flush_no_accept", {31'b0, out_valid1}, 32'd0);

        // Freeze holds contents
        in_valid = 1'b1; in_data = 32'hC; sb.push_back(32'hC);
        tick();
        in_valid = 1'b0; freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("frz_valid", {31'b0, out_valid1}, 32'd0);
            chk("frz_ready", {31'b0, in_ready1}, 32'd0);
            tick();
        end
        freeze = 1'b0;
        #1 chk("frz_cnt", {16'b0, frz1}, 32'd3);
        chk("frz_release_data", out_data1, 32'hC);
        chk("frz_release_valid", {31'b0, out_valid1}, 32'd1);
        tick();

        // Counter saturation and clear
        freeze = 1'b1;
        repeat (6) tick();
        #1 chk("sat_small", {30'b0, frz2}, 32'd3);
        chk("sat_big", {16'b0, frz1}, 32'd9);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0; freeze = 1'b0;
        #1 chk("clr_small", {30'b0, frz2}, 32'd0);
        chk("clr_big", {frz1, fls1}, 32'd0);
        chk("clr_drop", {16'b0, drp1}, 32'd0);

        // Flush and freeze together
        in_valid = 1'b1; in_data = 32'hD; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; freeze = 1'b1; flush = 1'b1;
        tick();
        freeze = 1'b0; flush = 1'b0;
        #1 chk("ff_frz", {16'b0, frz1}, 32'd1);
        chk("ff_fls", {16'b0, fls1}, 32'd1);
        chk("ff_drop", {16'b0, drp1}, 32'd1);
        chk("ff_valid", {31'b0, out_valid1}, 32'd0);

        // Flush while the head leaves downstream: not a drop
        in_valid = 1'b1; in_data = 32'hE; out_ready = 1'b1; sb.push_back(32'hE);
        tick();
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        #1 chk("fo_drop", {16'b0, drp1}, 32'd1);
        chk("fo_fls", {16'b0, fls1}, 32'd2);

        // Asynchronous reset between edges
        in_valid = 1'b1; in_data = 32'hF; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        #3 rst = 1'b0;
        #1 chk("ar_valid", {31'b0, out_valid1}, 32'd0);
        chk("ar_data", out_data1, 32'h0);
        chk("ar_cnts", {fls1, drp1}, 32'd0);
        chk("ar_ready", {31'b0, in_ready1}, 32'd0);
        tick();
        rst = 1'b1;
        #1 chk("ar_rel_ready", {31'b0, in_ready1}, 32'd1);
        in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b1; sb.push_back(32'h55);
        tick();
        in_valid = 1'b0;
        #1 chk("ar_first", out_data1, 32'h55);
        repeat (3) tick();
        chk("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
